// File: rtl/wb_regfile.sv
// Writeback-stage register file: load alignment, writeback source select,
// 31 x 32-bit architectural registers (x0 hardwired to zero), same-cycle
// read bypass of the value being written, and a retired-write counter.
module wb_regfile #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rd_wren_i,
    input  logic [1:0]  wb_sel_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] alu_data_i,
    input  logic [31:0] ld_data_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic [31:0] wb_data_o,
    output logic        wb_commit_o,
    output logic [31:0] retire_cnt_o
);

    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_aligned;
    logic [31:0] pc_plus4;
    logic [31:0] wb_data;
    logic        wr_en;

    logic [31:0] regs_q [1:31];
    logic        commit_q;
    logic [31:0] retire_q;
    logic [31:0] retire_d;

    assign rd       = instr_i[11:7];
    assign funct3   = instr_i[14:12];
    // Wraps naturally at 2^32.
    assign pc_plus4 = pc_i + 32'd4;

    // Writes to x0 and pipeline bubbles never reach the array or the counter.
    assign wr_en = rd_wren_i && (rd != 5'd0) && (instr_i != NOP_INSTR);

    // Extract and extend the addressed byte/halfword of the raw load word.
    always_comb begin
        ld_byte    = 8'h00;
        ld_aligned = ld_data_i;
        case (alu_data_i[1:0])
            2'd0:    ld_byte = ld_data_i[7:0];
            2'd1:    ld_byte = ld_data_i[15:8];
            2'd2:    ld_byte = ld_data_i[23:16];
            default: ld_byte = ld_data_i[31:24];
        endcase
        ld_half = alu_data_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];
        case (funct3)
            3'b000:  ld_aligned = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_aligned = {24'h000000, ld_byte};
            3'b001:  ld_aligned = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_aligned = {16'h0000, ld_half};
            default: ld_aligned = ld_data_i;
        endcase
    end

    // Writeback source select.
    always_comb begin
        wb_data = pc_plus4;
        case (wb_sel_i)
            2'd0:    wb_data = pc_plus4;
            2'd1:    wb_data = alu_data_i;
            2'd2:    wb_data = ld_aligned;
            default: wb_data = imm_i;
        endcase
    end

    assign wb_data_o = wb_data;

    // Read ports: x0 is zero, a matching in-flight write is forwarded,
    // otherwise the stored value. Not gated by reset on purpose.
    always_comb begin
        rs1_data_o = 32'h0;
        rs2_data_o = 32'h0;
        if (rs1_addr_i != 5'd0) begin
            rs1_data_o = (wr_en && (rs1_addr_i == rd)) ? wb_data : regs_q[rs1_addr_i];
        end
        if (rs2_addr_i != 5'd0) begin
            rs2_data_o = (wr_en && (rs2_addr_i == rd)) ? wb_data : regs_q[rs2_addr_i];
        end
    end

    // Register array update; reset clears every architectural register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else if (wr_en) begin
            regs_q[rd] <= wb_data;
        end
    end

    assign retire_d = retire_q + {31'h0, wr_en};

    // Commit pulse and retired-write counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            commit_q <= 1'b0;
            retire_q <= 32'h0;
        end else begin
            commit_q <= wr_en;
            retire_q <= retire_d;
        end
    end

    assign wb_commit_o  = commit_q;
    assign retire_cnt_o = retire_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile: table of writeback vectors with a queue of
// expected commits, plus hand sequences for reset and counter wrap.
module tb_wb_regfile;

    // Bubble encoding with a nonzero rd field, so the bubble filter is
    // distinguishable from the x0 filter.
    localparam logic [31:0] TB_NOP = 32'h00500293;

    logic        clk;
    logic        rst_n;
    logic        rd_wren;
    logic [1:0]  wb_sel;
    logic [31:0] pc, imm, instr, alu_data, ld_data;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data, wb_data, retire_cnt;
    logic        wb_commit;

    wb_regfile #(.NOP_INSTR(TB_NOP)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rd_wren_i    (rd_wren),
        .wb_sel_i     (wb_sel),
        .pc_i         (pc),
        .imm_i        (imm),
        .instr_i      (instr),
        .alu_data_i   (alu_data),
        .ld_data_i    (ld_data),
        .rs1_addr_i   (rs1_addr),
        .rs2_addr_i   (rs2_addr),
        .rs1_data_o   (rs1_data),
        .rs2_data_o   (rs2_data),
        .wb_data_o    (wb_data),
        .wb_commit_o  (wb_commit),
        .retire_cnt_o (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wren;
        logic [1:0]  sel;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [31:0] exp_wb;
        logic        exp_commit;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        commit;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mdl [32];
    logic [31:0] mcnt;
    int          n_cmp = 0;
    int          n_err = 0;
    vec_t        vecs[$];

    function automatic logic [31:0] mk_instr(input logic [4:0] rd, input logic [2:0] f3);
        return {17'h0, f3, rd, 7'b0000011};
    endfunction

    function automatic vec_t mk_vec(input logic wren, input logic [1:0] sel,
                                    input logic [31:0] p, input logic [31:0] im,
                                    input logic [31:0] ins, input logic [31:0] alu,
                                    input logic [31:0] ld, input logic [31:0] exp_wb,
                                    input logic exp_commit);
        vec_t v;
        v.wren = wren; v.sel = sel; v.pc = p; v.imm = im; v.instr = ins;
        v.alu = alu; v.ld = ld; v.exp_wb = exp_wb; v.exp_commit = exp_commit;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one vector, check combinational outputs and bypass, then check
    // the registered commit/counter and array contents after the edge.
    task automatic run_vec(input vec_t v);
        logic [4:0] rd;
        exp_t e;
        rd = v.instr[11:7];
        @(negedge clk);
        rd_wren = v.wren; wb_sel = v.sel; pc = v.pc; imm = v.imm;
        instr = v.instr; alu_data = v.alu; ld_data = v.ld;
        rs1_addr = rd; rs2_addr = rd;
        #1;
        chk("wb_data", wb_data, v.exp_wb);
        chk("rs1_bypass", rs1_data, v.exp_commit ? v.exp_wb : mdl[rd]);
        chk("rs2_bypass", rs2_data, v.exp_commit ? v.exp_wb : mdl[rd]);
        e.rd = rd; e.data = v.exp_wb; e.commit = v.exp_commit;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rd_wren = 1'b0;
        e = exp_q.pop_front();
        if (e.commit) begin
            mdl[e.rd] = e.data;
            mcnt = mcnt + 32'd1;
        end
        chk("wb_commit", {31'h0, wb_commit}, {31'h0, e.commit});
        chk("retire_cnt", retire_cnt, mcnt);
        #1;
        chk("rs1_array", rs1_data, mdl[rd]);
    endtask

    initial begin
        exp_t e;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        mcnt = 32'h0;
        rst_n = 1'b0; rd_wren = 1'b0; wb_sel = 2'd0; pc = 32'h0; imm = 32'h0;
        instr = 32'h0; alu_data = 32'h0; ld_data = 32'h0;
        rs1_addr = 5'd5; rs2_addr = 5'd31;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_commit", {31'h0, wb_commit}, 32'h0);
        chk("rst_retire", retire_cnt, 32'h0);
        chk("rst_rs1", rs1_data, 32'h0);
        chk("rst_rs2", rs2_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        //                 wren sel pc            imm           instr                   alu           ld            exp_wb        commit
        vecs.push_back(mk_vec(1, 1, 32'h0,        32'h0,        mk_instr(5, 3'b000),  32'h12345678, 32'h0,        32'h12345678, 1));
        vecs.push_back(mk_vec(1, 2, 32'h0,        32'h0,        mk_instr(6, 3'b000),  32'h00000002, 32'h80FF7F01, 32'hFFFFFFFF, 1));
        vecs.push_back(mk_vec(1, 2, 32'h0,        32'h0,        mk_instr(7, 3'b100),  32'h00000002, 32'h80FF7F01, 32'h000000FF, 1));
        vecs.push_back(mk_vec(1, 2, 32'h0,        32'h0,        mk_instr(8, 3'b001),  32'h00000002, 32'h80FF7F01, 32'hFFFF80FF, 1));
        vecs.push_back(mk_vec(1, 2, 32'h0,        32'h0,        mk_instr(9, 3'b101),  32'h00000002, 32'h80FF7F01, 32'h000080FF, 1));
        vecs.push_back(mk_vec(1, 2, 32'h0,        32'h0,        mk_instr(10, 3'b010), 32'h00000001, 32'h80FF7F01, 32'h80FF7F01, 1));
        vecs.push_back(mk_vec(1, 2, 32'h0,        32'h0,        mk_instr(11, 3'b011), 32'h00000003, 32'h80FF7F01, 32'h80FF7F01, 1));
        vecs.push_back(mk_vec(1, 2, 32'h0,        32'h0,        mk_instr(12, 3'b000), 32'h00000000, 32'h80FF7F01, 32'h00000001, 1));
        vecs.push_back(mk_vec(1, 2, 32'h0,        32'h0,        mk_instr(13, 3'b000), 32'h00000001, 32'h80FF7F01, 32'h0000007F, 1));
        vecs.push_back(mk_vec(1, 2, 32'h0,        32'h0,        mk_instr(14, 3'b000), 32'h00000003, 32'h80FF7F01, 32'hFFFFFF80, 1));
        vecs.push_back(mk_vec(1, 2, 32'h0,        32'h0,        mk_instr(15, 3'b001), 32'h00000000, 32'h80FF7F01, 32'h00007F01, 1));
        vecs.push_back(mk_vec(1, 1, 32'h0,        32'h0,        mk_instr(0, 3'b000),  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0));
        vecs.push_back(mk_vec(1, 1, 32'h0,        32'h0,        TB_NOP,               32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 0));
        vecs.push_back(mk_vec(1, 0, 32'hFFFFFFFC, 32'h0,        mk_instr(1, 3'b000),  32'h0,        32'h0,        32'h00000000, 1));
        vecs.push_back(mk_vec(1, 3, 32'h0,        32'hABCDE000, mk_instr(2, 3'b000),  32'h0,        32'h0,        32'hABCDE000, 1));
        vecs.push_back(mk_vec(1, 0, 32'h00001000, 32'h0,        mk_instr(3, 3'b000),  32'h0,        32'h0,        32'h00001004, 1));
        vecs.push_back(mk_vec(0, 1, 32'h0,        32'h0,        mk_instr(4, 3'b000),  32'h00005555, 32'h0,        32'h00005555, 0));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Fill x1..x31 with their own index.
        for (int i = 1; i < 32; i++) begin
            run_vec(mk_vec(1, 3, 32'h0, i, mk_instr(i[4:0], 3'b000), 32'h0, 32'h0, i, 1));
        end

        // Independent bypass: rs1 hits the in-flight write, rs2 reads the array.
        @(negedge clk);
        rd_wren = 1'b1; wb_sel = 2'd3; imm = 32'h20202020; instr = mk_instr(20, 3'b000);
        rs1_addr = 5'd20; rs2_addr = 5'd21;
        #1;
        chk("indep_rs1", rs1_data, 32'h20202020);
        chk("indep_rs2", rs2_data, 32'd21);
        e.rd = 5'd20; e.data = 32'h20202020; e.commit = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rd_wren = 1'b0;
        e = exp_q.pop_front();
        mdl[e.rd] = e.data;
        mcnt = mcnt + 32'd1;
        chk("indep_commit", {31'h0, wb_commit}, {31'h0, e.commit});
        chk("indep_retire", retire_cnt, mcnt);

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int a = 1; a < 32; a++) begin
            rs1_addr = a[4:0];
            rs2_addr = 5'(32 - a);
            #1;
            chk("rst_mid_rs1", rs1_data, 32'h0);
            chk("rst_mid_rs2", rs2_data, 32'h0);
        end
        chk("rst_mid_retire", retire_cnt, 32'h0);
        chk("rst_mid_commit", {31'h0, wb_commit}, 32'h0);

        // Bypass still works while in reset, but the edge's write is lost.
        rd_wren = 1'b1; wb_sel = 2'd1; alu_data = 32'hA5A5A5A5; instr = mk_instr(3, 3'b000);
        rs1_addr = 5'd3; rs2_addr = 5'd4;
        #1;
        chk("rst_bypass_rs1", rs1_data, 32'hA5A5A5A5);
        chk("rst_bypass_rs2", rs2_data, 32'h0);
        @(posedge clk);
        #1;
        rd_wren = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        mcnt = 32'h0;
        #1;
        chk("rst_lost_write", rs1_data, 32'h0);
        chk("rst_lost_commit", {31'h0, wb_commit}, 32'h0);
        chk("rst_lost_retire", retire_cnt, 32'h0);

        // Counter wrap from all-ones.
        @(negedge clk);
        force dut.retire_q = 32'hFFFFFFFF;
        #1;
        chk("wrap_preset", retire_cnt, 32'hFFFFFFFF);
        release dut.retire_q;
        mcnt = 32'hFFFFFFFF;
        run_vec(mk_vec(1, 1, 32'h0, 32'h0, mk_instr(9, 3'b000), 32'h99999999, 32'h0, 32'h99999999, 1));
        chk("wrap_zero", retire_cnt, 32'h0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h00000013, meaning the bubble encoding that is never written back.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous and active-low.
REQ-004 rd_wren_i  in  1  writeback enable from the ME/WB pipeline register.
REQ-005 wb_sel_i  in  2  writeback source: 0 = pc_i+4, 1 = alu_data_i, 2 = aligned load data, 3 = imm_i.
REQ-006 pc_i, imm_i, instr_i, alu_data_i  in  32 each  WB-stage PC, immediate, instruction, ALU result (load address for loads).
REQ-007 ld_data_i  in  32  raw word read from the word-aligned data-memory address.
REQ-008 rs1_addr_i, rs2_addr_i  in  5 each  decode-stage read addresses.
REQ-009 rs1_data_o, rs2_data_o  out  32 each  read data, combinational.
REQ-010 wb_data_o  out  32  selected writeback value, combinational, for debug.
REQ-011 wb_commit_o  out  1  registered pulse: a register write occurred last cycle.
REQ-012 retire_cnt_o  out  32  registered count of committed writes.

Function
REQ-013 Destination rd = instr_i[11:7]; funct3 = instr_i[14:12]; byte offset = alu_data_i[1:0].
REQ-014 Load alignment (wb_sel_i==2): funct3 000 LB sign-extends the byte at offset; 100 LBU zero-extends it; 001 LH sign-extends the halfword selected by alu_data_i[1]; 101 LHU zero-extends it; 010 LW passes ld_data_i; other funct3 yields ld_data_i unchanged.
REQ-015 pc_i+4 SHALL be computed modulo 2^32 (PC 32'hFFFFFFFC yields 0).
REQ-016 Write condition: rd_wren_i==1 and rd!=0 and instr_i!=NOP_INSTR; the register file is updated on the rising edge.
REQ-017 x0 SHALL read 0 always; writes to x0 are discarded and SHALL NOT count as commits.
REQ-018 Read ports SHALL bypass: if the write condition holds this cycle and rsN_addr_i==rd (rd!=0), rsN_data_o = wb_data_o; otherwise array contents.
REQ-019 Both read ports SHALL bypass independently; rs1_addr_i==rs2_addr_i==rd returns wb_data_o on both.
REQ-020 wb_commit_o SHALL be 1 in the cycle following each write and 0 otherwise.
REQ-021 retire_cnt_o SHALL increment by 1 per write, wrap from 32'hFFFFFFFF to 0, and never increment on a blocked write.
REQ-022 Storage SHALL be 31 x 32-bit registers (x1..x31); no x0 storage.

Reset
REQ-023 rst_ni low SHALL asynchronously clear all x1..x31 to 0, wb_commit_o to 0, and retire_cnt_o to 0, independent of clk_i.
REQ-024 A write whose clock edge coincides with rst_ni low SHALL be lost; the register reads 0 after reset.
REQ-025 rs*_data_o during reset SHALL be 0 unless bypass applies (combinational path unaffected by reset).

Verification
REQ-026 Reset, then rd_wren_i=1, wb_sel_i=1, alu_data_i=32'h12345678, instr_i rd=5 -> same cycle rs1_addr_i=5 gives 32'h12345678 via bypass; next cycle from array; wb_commit_o=1; retire_cnt_o=1.
REQ-027 LB, ld_data_i=32'h80FF7F01, alu_data_i[1:0]=2 -> x6=32'hFFFFFFFF; LBU same -> 32'h000000FF; LH alu_data_i[1]=1 -> 32'hFFFF80FF; LHU -> 32'h000080FF.
REQ-028 Write rd=0 with alu_data_i=32'hDEADBEEF -> rs1_data_o for x0 stays 0; wb_commit_o=0; retire_cnt_o unchanged.
REQ-029 instr_i=NOP_INSTR with rd_wren_i=1 -> no write, no commit; wb_sel_i=0, pc_i=32'hFFFFFFFC, rd=1 -> x1=0; wb_sel_i=3, imm_i=32'hABCDE000 -> imm written.
REQ-030 Fill x1..x31 with index values, assert rst_ni low mid-cycle -> all reads 0 before next edge, retire_cnt_o=0; force retire_cnt_o path to 32'hFFFFFFFF then one write -> 0.
